// File: rtl/vend_pkg.sv
// Shared definitions for the vending controller: state encoding and coin codes.
package vend_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_COLLECT = 2'd1;
    localparam state_t ST_VEND    = 2'd2;

    typedef logic [1:0] coin_t;

    localparam coin_t COIN_NONE = 2'b00;
    localparam coin_t COIN_A    = 2'b01;
    localparam coin_t COIN_B    = 2'b10;
    localparam coin_t COIN_C    = 2'b11;

endpackage

// File: rtl/vend_coin_decode.sv
// Combinational mapping from the acceptor's coin code to its credit value.
module vend_coin_decode
    import vend_pkg::*;
#(
    parameter int unsigned VAL_A    = 1,
    parameter int unsigned VAL_B    = 2,
    parameter int unsigned VAL_C    = 4,
    parameter int unsigned CREDIT_W = 4
) (
    input  logic [1:0]          coin,
    output logic [CREDIT_W-1:0] value
);

    always_comb begin
        value = '0;
        case (coin)
            COIN_A:  value = CREDIT_W'(VAL_A);
            COIN_B:  value = CREDIT_W'(VAL_B);
            COIN_C:  value = CREDIT_W'(VAL_C);
            default: value = '0;
        endcase
    end

endmodule

// File: rtl/vend_fsm_param.sv
// Parametrised vending controller: credit accumulation, dispense, change,
// cancel refund, coin rejection and a wrapping sales counter.
module vend_fsm_param
    import vend_pkg::*;
#(
    parameter int unsigned PRICE    = 3,
    parameter int unsigned VAL_A    = 1,
    parameter int unsigned VAL_B    = 2,
    parameter int unsigned VAL_C    = 4,
    parameter int unsigned CREDIT_W = 4,
    parameter int unsigned CNT_W    = 8
) (
    input  logic                CLK_IN,
    input  logic                RST,
    input  logic [1:0]          COIN,
    input  logic                CANCEL,
    output logic                DRINK_OUT,
    output logic                CHANGE_VALID,
    output logic [CREDIT_W-1:0] CHANGE_AMT,
    output logic                COIN_REJ,
    output logic [CREDIT_W-1:0] CREDIT,
    output logic                BUSY,
    output logic [CNT_W-1:0]    VEND_CNT
);

    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);

    state_t              state;
    logic [CREDIT_W-1:0] coin_val;
    logic [CREDIT_W-1:0] sum;
    logic                coin_present;

    vend_coin_decode #(
        .VAL_A    (VAL_A),
        .VAL_B    (VAL_B),
        .VAL_C    (VAL_C),
        .CREDIT_W (CREDIT_W)
    ) u_decode (
        .coin  (COIN),
        .value (coin_val)
    );

    // Width rule on CREDIT_W guarantees this sum never wraps.
    assign sum          = CREDIT + coin_val;
    assign coin_present = (COIN != COIN_NONE);

    always_ff @(posedge CLK_IN or posedge RST) begin
        if (RST) begin
            state        <= ST_IDLE;
            CREDIT       <= '0;
            DRINK_OUT    <= 1'b0;
            CHANGE_VALID <= 1'b0;
            CHANGE_AMT   <= '0;
            COIN_REJ     <= 1'b0;
            BUSY         <= 1'b0;
            VEND_CNT     <= '0;
        end else begin
            DRINK_OUT    <= 1'b0;
            CHANGE_VALID <= 1'b0;
            CHANGE_AMT   <= '0;
            COIN_REJ     <= 1'b0;
            case (state)
                ST_IDLE, ST_COLLECT: begin
                    if (coin_present && !CANCEL) begin
                        CREDIT <= sum;
                        if (sum >= PRICE_C) begin
                            state <= ST_VEND;
                            BUSY  <= 1'b1;
                        end else begin
                            state <= ST_COLLECT;
                        end
                    end else if (CANCEL) begin
                        // A coin arriving with cancel is bounced, never added to the refund.
                        COIN_REJ <= coin_present;
                        if (state == ST_COLLECT) begin
                            CHANGE_VALID <= 1'b1;
                            CHANGE_AMT   <= CREDIT;
                            CREDIT       <= '0;
                            state        <= ST_IDLE;
                        end
                    end
                end
                ST_VEND: begin
                    DRINK_OUT <= 1'b1;
                    VEND_CNT  <= VEND_CNT + 1'b1;
                    if (CREDIT > PRICE_C) begin
                        CHANGE_VALID <= 1'b1;
                        CHANGE_AMT   <= CREDIT - PRICE_C;
                    end
                    COIN_REJ <= coin_present;
                    CREDIT   <= '0;
                    BUSY     <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: begin
                    state  <= ST_IDLE;
                    CREDIT <= '0;
                    BUSY   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vend_fsm_param.sv
// Directed bench for vend_fsm_param with default parameters.
module tb_vend_fsm_param;

    logic       CLK_IN = 1'b0;
    logic       RST    = 1'b0;
    logic [1:0] COIN   = 2'b00;
    logic       CANCEL = 1'b0;
    logic       DRINK_OUT;
    logic       CHANGE_VALID;
    logic [3:0] CHANGE_AMT;
    logic       COIN_REJ;
    logic [3:0] CREDIT;
    logic       BUSY;
    logic [7:0] VEND_CNT;

    int checks = 0;
    int passed = 0;
    int failed = 0;

    vend_fsm_param dut (
        .CLK_IN       (CLK_IN),
        .RST          (RST),
        .COIN         (COIN),
        .CANCEL       (CANCEL),
        .DRINK_OUT    (DRINK_OUT),
        .CHANGE_VALID (CHANGE_VALID),
        .CHANGE_AMT   (CHANGE_AMT),
        .COIN_REJ     (COIN_REJ),
        .CREDIT       (CREDIT),
        .BUSY         (BUSY),
        .VEND_CNT     (VEND_CNT)
    );

    always #5 CLK_IN = ~CLK_IN;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passed++;
        end else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic d, input logic cv,
                           input logic [3:0] amt, input logic rej, input logic [3:0] cr,
                           input logic busy, input logic [7:0] cnt);
        chk({tag, ".drink"},  32'(DRINK_OUT),    32'(d));
        chk({tag, ".chg_v"},  32'(CHANGE_VALID), 32'(cv));
        chk({tag, ".chg_amt"}, 32'(CHANGE_AMT),  32'(amt));
        chk({tag, ".rej"},    32'(COIN_REJ),     32'(rej));
        chk({tag, ".credit"}, 32'(CREDIT),       32'(cr));
        chk({tag, ".busy"},   32'(BUSY),         32'(busy));
        chk({tag, ".cnt"},    32'(VEND_CNT),     32'(cnt));
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
    task automatic step(input logic [1:0] c, input logic can);
        COIN   = c;
        CANCEL = can;
        @(posedge CLK_IN);
        #1;
    endtask

    initial begin
        #3 RST = 1'b1;
        #1 chk_all("rst_async", 0, 0, 4'd0, 0, 4'd0, 0, 8'd0);
        @(posedge CLK_IN); #1;
        RST = 1'b0;
        step(2'b00, 0);
        step(2'b00, 0);
        chk_all("rst_idle", 0, 0, 4'd0, 0, 4'd0, 0, 8'd0);

        step(2'b01, 0); chk_all("exact1", 0, 0, 4'd0, 0, 4'd1, 0, 8'd0);
        step(2'b01, 0); chk_all("exact2", 0, 0, 4'd0, 0, 4'd2, 0, 8'd0);
        step(2'b01, 0); chk_all("exact3", 0, 0, 4'd0, 0, 4'd3, 1, 8'd0);
        step(2'b00, 0); chk_all("exact_vend", 1, 0, 4'd0, 0, 4'd0, 0, 8'd1);
        step(2'b00, 0); chk_all("exact_after", 0, 0, 4'd0, 0, 4'd0, 0, 8'd1);

        step(2'b01, 0); chk_all("over_a", 0, 0, 4'd0, 0, 4'd1, 0, 8'd1);
        step(2'b11, 0); chk_all("over_c", 0, 0, 4'd0, 0, 4'd5, 1, 8'd1);
        step(2'b00, 0); chk_all("over_vend", 1, 1, 4'd2, 0, 4'd0, 0, 8'd2);
        step(2'b00, 0); chk_all("over_after", 0, 0, 4'd0, 0, 4'd0, 0, 8'd2);

        step(2'b10, 0); chk_all("bb1", 0, 0, 4'd0, 0, 4'd2, 0, 8'd2);
        step(2'b10, 0); chk_all("bb2", 0, 0, 4'd0, 0, 4'd4, 1, 8'd2);
        step(2'b00, 0); chk_all("bb_vend", 1, 1, 4'd1, 0, 4'd0, 0, 8'd3);

        step(2'b10, 0); chk_all("can_coin", 0, 0, 4'd0, 0, 4'd2, 0, 8'd3);
        step(2'b00, 1); chk_all("can_refund", 0, 1, 4'd2, 0, 4'd0, 0, 8'd3);
        step(2'b00, 1); chk_all("can_idle", 0, 0, 4'd0, 0, 4'd0, 0, 8'd3);
        step(2'b01, 1); chk_all("can_idle_coin", 0, 0, 4'd0, 1, 4'd0, 0, 8'd3);

        step(2'b11, 0); chk_all("rej_enter", 0, 0, 4'd0, 0, 4'd4, 1, 8'd3);
        step(2'b01, 0); chk_all("rej_vend", 1, 1, 4'd1, 1, 4'd0, 0, 8'd4);
        step(2'b00, 0); chk_all("rej_after", 0, 0, 4'd0, 0, 4'd0, 0, 8'd4);

        step(2'b10, 0); chk_all("rejc_coin", 0, 0, 4'd0, 0, 4'd2, 0, 8'd4);
        step(2'b01, 1); chk_all("rejc_refund", 0, 1, 4'd2, 1, 4'd0, 0, 8'd4);
        step(2'b00, 0); chk_all("rejc_after", 0, 0, 4'd0, 0, 4'd0, 0, 8'd4);

        for (int i = 0; i < 252; i++) begin
            step(2'b11, 0);
            step(2'b00, 0);
        end
        chk_all("wrap", 1, 1, 4'd1, 0, 4'd0, 0, 8'd0);
        step(2'b11, 0);
        step(2'b00, 0);
        chk("wrap_plus1.cnt", 32'(VEND_CNT), 32'd1);

        step(2'b01, 0); chk_all("rstmid_coin", 0, 0, 4'd0, 0, 4'd1, 0, 8'd1);
        COIN = 2'b00;
        #2 RST = 1'b1;
        #1 chk_all("rstmid_async", 0, 0, 4'd0, 0, 4'd0, 0, 8'd0);
        @(posedge CLK_IN); #1;
        RST = 1'b0;
        step(2'b00, 0); chk_all("rstmid_after", 0, 0, 4'd0, 0, 4'd0, 0, 8'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/vend_fsm_param.md
# vend_fsm_param

Parametrised vending-machine controller: the next generation of the fixed 1.5-unit seller FSM. It accumulates coin credit against a configurable price and supports three coin denominations. It returns change, refunds on cancel, rejects coins while vending, and keeps a wrapping sales counter. It sits between the coin-acceptor front end (2-bit coin code) and the dispense/change actuators.

## Interface
- PRICE, 3: price of one drink in credit units (1 unit = smallest coin); must be ≥1.
- VAL_A, 1: credit value of coin code 2'b01.
- VAL_B, 2: credit value of coin code 2'b10.
- VAL_C, 4: credit value of coin code 2'b11.
- CREDIT_W, 4: credit/change width; must satisfy 2^CREDIT_W > PRICE-1+max(VAL_A,VAL_B,VAL_C).
- CNT_W, 8: sales counter width.

Ports:
- CLK_IN  in  1  clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- COIN  in  2  coin code, sampled every edge: 00 none, 01/10/11 denominations A/B/C.
- CANCEL  in  1  refund request, level-sampled every edge.
- DRINK_OUT  out  1  one-cycle dispense pulse.
- CHANGE_VALID  out  1  one-cycle pulse; CHANGE_AMT valid while high.
- CHANGE_AMT  out  CREDIT_W  change/refund amount; 0 when CHANGE_VALID low.
- COIN_REJ  out  1  one-cycle pulse: coin presented while not accepting.
- CREDIT  out  CREDIT_W  current accumulated credit.
- BUSY  out  1  high in VEND state.
- VEND_CNT  out  CNT_W  drinks dispensed since reset, wraps to 0.

## Operation
- States: IDLE (credit 0), COLLECT (0 < credit < PRICE), VEND (credit ≥ PRICE, dispense pending).
- IDLE/COLLECT, COIN≠00, CANCEL=0: sum = credit + value(COIN). If sum ≥ PRICE, credit←sum and go to VEND. Otherwise credit←sum and go to (or stay in) COLLECT.
- COLLECT, CANCEL=1: CHANGE_VALID←1, CHANGE_AMT←credit, credit←0, go to IDLE. If a coin is presented on the same edge, it is rejected (COIN_REJ←1) and is not refunded.
- IDLE, CANCEL=1: no action. A coin on the same edge is rejected.
- VEND, unconditionally on the next edge:
  - DRINK_OUT←1; VEND_CNT←VEND_CNT+1 (mod 2^CNT_W).
  - If credit > PRICE: CHANGE_VALID←1, CHANGE_AMT←credit−PRICE.
  - credit←0; go to IDLE.
  - A coin on this edge is rejected (COIN_REJ←1); CANCEL is ignored.
- Credit carries no overflow. Arithmetic is unsigned in CREDIT_W bits, which the CREDIT_W rule guarantees is sufficient.
- Unreachable state encodings return to IDLE with credit 0.

## Timing
- All outputs are registered.
- Reset values: DRINK_OUT, CHANGE_VALID, COIN_REJ and BUSY are 0; CHANGE_AMT, CREDIT and VEND_CNT are 0; state is IDLE.
- Coin-to-dispense latency: a coin completing the price at edge k sets BUSY=1 and CREDIT=sum after edge k. DRINK_OUT and change pulse after edge k+1, with CREDIT=0 and BUSY=0.
- Cancel-to-refund latency: 1 edge.
- DRINK_OUT, CHANGE_VALID and COIN_REJ are single-cycle pulses. Back-to-back vends are possible every 2 cycles.
- RST mid-operation (any state) discards credit immediately: no refund pulse and no dispense. VEND_CNT clears.

## Structure
- Shared package vend_pkg holds:
  - state typedef/encoding (IDLE, COLLECT, VEND);
  - coin code constants (COIN_NONE, COIN_A, COIN_B, COIN_C).
- Sub-module vend_coin_decode: combinational code→credit value, parameterised by VAL_A/B/C and CREDIT_W.
- Top level holds state register, credit register, output registers and sales counter.

## Test plan
All scenarios use default parameters.
- Reset: assert RST asynchronously mid-cycle -> all outputs 0 immediately. After release with COIN=00, the outputs hold 0.
- Exact payment: COIN 01,01,01 on three edges -> CREDIT 1,2,3 with BUSY=1 after the third edge. Next edge: DRINK_OUT=1 for one cycle, CHANGE_VALID=0, CREDIT=0, VEND_CNT=1.
- Overpayment: COIN 01 then 11 -> CREDIT=5, then DRINK_OUT=1 with CHANGE_VALID=1 and CHANGE_AMT=2. Separately, COIN 10,10 -> CHANGE_AMT=1.
- Cancel: COIN 10 then CANCEL -> CHANGE_VALID=1, CHANGE_AMT=2, DRINK_OUT=0, CREDIT=0. CANCEL in IDLE -> no pulses.
- Rejection: COIN 11 (enter VEND), then COIN 01 on the VEND edge -> COIN_REJ=1 with DRINK_OUT=1, and CREDIT=0 afterwards. Repeat with CANCEL+COIN 01 in COLLECT -> refund equals prior credit only, COIN_REJ=1.
- Counter wrap and reset mid-collect: 256 vends -> VEND_CNT returns to 0. COIN 01 then RST -> CREDIT=0, no CHANGE_VALID.
